// File: rtl/reorder_buffer_pkg.sv
// Shared definitions for the reorder buffer: sizing, tag sentinel, entry kinds,
// jump order codes and the per-entry payload layout.
package reorder_buffer_pkg;

  localparam int unsigned DEPTH  = 16;
  localparam int unsigned XLEN   = 32;
  localparam int unsigned REG_W  = 5;

  localparam logic [XLEN-1:0] NO_TAG = 32'hFFFF_FFFF;

  // Order codes of the jump instructions as seen by the decoder
  localparam logic [5:0] ORDER_JAL  = 6'd30;
  localparam logic [5:0] ORDER_JALR = 6'd12;

  typedef enum logic [1:0] {
    KIND_REG    = 2'd0,
    KIND_STORE  = 2'd1,
    KIND_JALR   = 2'd2,
    KIND_BRANCH = 2'd3
  } kind_e;

  // Payload held per entry; busy/ready live in separate vectors so they can be reset
  typedef struct packed {
    kind_e             kind;
    logic [REG_W-1:0]  rd;
    logic [XLEN-1:0]   value;
    logic [XLEN-1:0]   topc;
    logic [XLEN-1:0]   pred_pc;
    logic              pred_taken;
    logic [XLEN-1:0]   target;
    logic [XLEN-1:0]   fall;
  } rob_entry_t;

endpackage

// File: rtl/reorder_buffer.sv
// Circular reorder buffer: allocates an entry per issued instruction, captures
// station/load results by tag, retires one entry per cycle in program order and
// flushes everything on a mispredicted JALR/BRANCH at commit.
// Ports:
//   clk, rst, rdy                  clock, async active-high reset, global enable
//   alloc_*                        issue request and per-kind prediction info
//   full, alloc_tag                registered occupancy flag and next tag
//   RS_ROB/RS_ROB2/data2*          station writeback (value, optional target PC)
//   SLB_ROB/data4/load_value       store/load buffer writeback
//   q_tag_*/q_ready_*/q_value_*    combinational operand queries
//   ROB_RS/data3/data3_RS          commit broadcast
//   commit_we/commit_rd            register file write
//   commit_store                   release head store
//   clear/clear_pc                 flush pulse and redirect PC
module reorder_buffer #(
  parameter int unsigned DEPTH  = reorder_buffer_pkg::DEPTH,
  parameter logic [31:0] NO_TAG = reorder_buffer_pkg::NO_TAG
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        alloc_valid,
  input  logic [1:0]  alloc_kind,
  input  logic [4:0]  alloc_rd,
  input  logic [31:0] alloc_pred_pc,
  input  logic        alloc_pred_taken,
  input  logic [31:0] alloc_target,
  input  logic [31:0] alloc_fall,
  output logic        full,
  output logic [31:0] alloc_tag,
  input  logic        RS_ROB,
  input  logic        RS_ROB2,
  input  logic [31:0] data2,
  input  logic [31:0] data2_value,
  input  logic [31:0] data2_topc,
  input  logic        SLB_ROB,
  input  logic [31:0] data4,
  input  logic [31:0] load_value,
  input  logic [31:0] q_tag_j,
  input  logic [31:0] q_tag_k,
  output logic        q_ready_j,
  output logic        q_ready_k,
  output logic [31:0] q_value_j,
  output logic [31:0] q_value_k,
  output logic        ROB_RS,
  output logic [31:0] data3,
  output logic [31:0] data3_RS,
  output logic        commit_we,
  output logic [4:0]  commit_rd,
  output logic        commit_store,
  output logic        clear,
  output logic [31:0] clear_pc
);
  import reorder_buffer_pkg::*;

  localparam int unsigned PTR_BITS = $clog2(DEPTH);
  localparam int unsigned CNT_BITS = $clog2(DEPTH + 1);

  logic [DEPTH-1:0]    busy;
  logic [DEPTH-1:0]    ready;
  rob_entry_t          ent [DEPTH];
  logic [PTR_BITS-1:0] head;
  logic [PTR_BITS-1:0] tail;
  logic [CNT_BITS-1:0] count;

  logic [PTR_BITS-1:0] head_nx;
  logic [PTR_BITS-1:0] tail_nx;
  logic [CNT_BITS-1:0] count_nx;
  logic [PTR_BITS-1:0] wb_rs_idx;
  logic [PTR_BITS-1:0] wb_slb_idx;
  logic                alloc_fire;
  logic                wb_rs;
  logic                wb_slb;
  logic                commit_fire;
  logic                mispredict;
  logic [31:0]         redirect_pc;
  rob_entry_t          head_ent;

  // A tag names a real entry only when it is in range and not the sentinel
  function automatic logic tag_ok(input logic [31:0] tag);
    return (tag != NO_TAG) && (tag < 32'(DEPTH));
  endfunction

  // Per-cycle decisions, all taken from start-of-cycle state
  always_comb begin
    head_ent    = ent[head];
    wb_rs_idx   = data2[PTR_BITS-1:0];
    wb_slb_idx  = data4[PTR_BITS-1:0];
    alloc_fire  = rdy && !clear && alloc_valid && (count != CNT_BITS'(DEPTH));
    wb_rs       = rdy && !clear && RS_ROB && tag_ok(data2) && busy[wb_rs_idx];
    wb_slb      = rdy && !clear && SLB_ROB && tag_ok(data4) && busy[wb_slb_idx];
    commit_fire = rdy && busy[head] && ready[head];
    mispredict  = 1'b0;
    redirect_pc = '0;
    if (commit_fire) begin
      case (head_ent.kind)
        KIND_JALR: begin
          if (head_ent.topc != head_ent.pred_pc) begin
            mispredict  = 1'b1;
            redirect_pc = head_ent.topc;
          end
        end
        KIND_BRANCH: begin
          if (head_ent.value[0] != head_ent.pred_taken) begin
            mispredict  = 1'b1;
            redirect_pc = head_ent.value[0] ? head_ent.target : head_ent.fall;
          end
        end
        default: ;
      endcase
    end
  end

  // Pointer and occupancy update; a flush overrides everything
  always_comb begin
    head_nx  = head;
    tail_nx  = tail;
    count_nx = count + CNT_BITS'(alloc_fire) - CNT_BITS'(commit_fire);
    if (commit_fire) head_nx = head + PTR_BITS'(1);
    if (alloc_fire)  tail_nx = tail + PTR_BITS'(1);
    if (mispredict) begin
      head_nx  = '0;
      tail_nx  = '0;
      count_nx = '0;
    end
  end

  // Control state, entry flags and registered commit/flush outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head         <= '0;
      tail         <= '0;
      count        <= '0;
      busy         <= '0;
      ready        <= '0;
      full         <= 1'b0;
      alloc_tag    <= '0;
      ROB_RS       <= 1'b0;
      data3        <= '0;
      data3_RS     <= '0;
      commit_we    <= 1'b0;
      commit_rd    <= '0;
      commit_store <= 1'b0;
      clear        <= 1'b0;
      clear_pc     <= '0;
    end else if (rdy) begin
      head      <= head_nx;
      tail      <= tail_nx;
      count     <= count_nx;
      full      <= (count_nx == CNT_BITS'(DEPTH));
      alloc_tag <= 32'(tail_nx);

      if (wb_rs)  ready[wb_rs_idx]  <= 1'b1;
      if (wb_slb) ready[wb_slb_idx] <= 1'b1;
      if (alloc_fire) begin
        busy[tail]  <= 1'b1;
        ready[tail] <= 1'b0;
      end
      if (commit_fire) busy[head] <= 1'b0;
      if (mispredict)  busy <= '0;

      ROB_RS       <= commit_fire;
      commit_we    <= commit_fire && (head_ent.rd != '0) &&
                      ((head_ent.kind == KIND_REG) || (head_ent.kind == KIND_JALR));
      commit_store <= commit_fire && (head_ent.kind == KIND_STORE);
      clear        <= mispredict;
      if (commit_fire) begin
        data3     <= 32'(head);
        data3_RS  <= head_ent.value;
        commit_rd <= head_ent.rd;
      end
      if (mispredict) clear_pc <= redirect_pc;
    end
  end

  // Entry payload; validity is tracked by busy, so no reset is needed here
  always_ff @(posedge clk) begin
    if (alloc_fire) begin
      ent[tail].kind       <= kind_e'(alloc_kind);
      ent[tail].rd         <= alloc_rd;
      ent[tail].pred_pc    <= alloc_pred_pc;
      ent[tail].pred_taken <= alloc_pred_taken;
      ent[tail].target     <= alloc_target;
      ent[tail].fall       <= alloc_fall;
    end
    if (wb_rs) begin
      ent[wb_rs_idx].value <= data2_value;
      if (RS_ROB2) ent[wb_rs_idx].topc <= data2_topc;
    end
    if (wb_slb) ent[wb_slb_idx].value <= load_value;
  end

  // Operand queries read registered state only
  always_comb begin
    q_ready_j = 1'b0;
    q_value_j = '0;
    q_ready_k = 1'b0;
    q_value_k = '0;
    if (tag_ok(q_tag_j) && busy[q_tag_j[PTR_BITS-1:0]]) begin
      q_ready_j = ready[q_tag_j[PTR_BITS-1:0]];
      q_value_j = ent[q_tag_j[PTR_BITS-1:0]].value;
    end
    if (tag_ok(q_tag_k) && busy[q_tag_k[PTR_BITS-1:0]]) begin
      q_ready_k = ready[q_tag_k[PTR_BITS-1:0]];
      q_value_k = ent[q_tag_k[PTR_BITS-1:0]].value;
    end
  end

endmodule

// File: doc/reorder_buffer.md
# reorder_buffer

- 16-entry circular reorder buffer. Sits directly downstream of the reservation station and the store/load buffer, and upstream of the register file.
- Allocates one entry per issued instruction and captures execution and load results by tag.
- Commits at most one entry per cycle, in program order. Each commit broadcasts the result to waiting stations and writes the register file.
- A mispredicted JALR or branch at commit triggers a global flush with a redirect PC.

## Interface
Parameters:
- DEPTH, 16, entry count; tags are entry indices 0..DEPTH-1.
- NO_TAG, 32'hFFFF_FFFF, "no producer" tag value.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- rdy  in  1  global enable; when 0 all state and outputs hold
- alloc_valid  in  1  issue request this cycle
- alloc_kind  in  2  0=REG, 1=STORE, 2=JALR, 3=BRANCH
- alloc_rd  in  5  destination register (REG/JALR)
- alloc_pred_pc  in  32  predicted next PC (JALR)
- alloc_pred_taken  in  1  predicted direction (BRANCH)
- alloc_target / alloc_fall  in  32 each  taken / not-taken PC (BRANCH)
- full  out  1  count==DEPTH
- alloc_tag  out  32  tail index, valid whenever !full
- RS_ROB, RS_ROB2  in  1 each  station result valid / topc valid
- data2, data2_value, data2_topc  in  32 each  tag, value (BRANCH: bit0=taken), computed target
- SLB_ROB  in  1  load value or store-address completion valid
- data4, load_value  in  32 each  tag, value
- q_tag_j, q_tag_k  in  32 each  issue-time operand queries
- q_ready_j, q_ready_k  out  1 each  entry busy and ready
- q_value_j, q_value_k  out  32 each  stored value
- ROB_RS  out  1  commit broadcast valid
- data3, data3_RS  out  32 each  committed tag, value
- commit_we  out  1  register write (REG/JALR, rd!=0)
- commit_rd  out  5  destination register
- commit_store  out  1  release head store to store/load buffer
- clear  out  1  one-cycle flush
- clear_pc  out  32  redirect target

## Operation
- Per-entry state: busy, ready, kind, rd, value, topc, pred_pc, pred_taken, target, fall. Pointers: head, tail (4-bit, wrap modulo 16). Counter: count (5-bit, 0..16).
- Allocate when alloc_valid && !full: entry[tail] gets busy=1, ready=0; tail+1.
- full is computed from the start-of-cycle count. A same-cycle commit does not free space for a same-cycle allocation.
- Writeback RS_ROB: entry[data2] gets value, and ready=1; topc is also written when RS_ROB2=1.
- Writeback SLB_ROB: entry[data4] gets value=load_value, ready=1.
- Both writebacks may occur in the same cycle. They always target different tags.
- Writebacks to non-busy entries are ignored.
- Commit: if entry[head] is busy and ready at the start of the cycle, at the edge:
  - busy=0, head+1, count-1.
  - ROB_RS=1, data3=head, data3_RS=value.
  - Per kind: REG → commit_we (suppressed when rd=0). STORE → commit_store. JALR → commit_we with value (the link).
- Mispredict at commit:
  - JALR when topc!=pred_pc → clear_pc=topc.
  - BRANCH when value[0]!=pred_taken → clear_pc = taken ? target : fall.
  - The committing entry still retires normally. At the same edge all entries go busy=0 and head=tail=count=0; clear=1 next cycle.
- While clear=1, all alloc and writeback inputs are ignored.
- Queries are combinational from registered state only. There is no same-cycle writeback bypass. A query with tag NO_TAG or a non-busy tag returns ready=0, value=0.

## Timing
- All outputs except q_* are registered pulses, valid for exactly one cycle after the commit edge.
- Latency: writeback at edge N → commit at edge N+1 at the earliest → ROB_RS high during cycle N+1..N+2.
- rst (any time, including mid-flush): head=tail=count=0, all busy=0, and every output is 0. This includes data3, data3_RS, clear_pc and alloc_tag, with full=0.
- rdy=0: nothing allocates, writes back or commits, and pulse outputs hold their values.
- Empty (count=0): no commit. Full (count=16): alloc_valid is ignored; the issue stage must gate on full.

## Structure
- Shared package holds:
  - kind encodings (KIND_REG, KIND_STORE, KIND_JALR, KIND_BRANCH)
  - JAL/JALR order codes (6'd30, 6'd12)
  - NO_TAG, DEPTH
- No sub-module. Entry storage is flat arrays inside the block.

## Test plan
- Reset then allocate REG rd=5 at tag 0; RS writes tag 0 value 32'h1234 → next edge ROB_RS=1, data3=0, data3_RS=32'h1234, commit_we=1, commit_rd=5.
- Out-of-order writeback: allocate tags 0,1; tag 1 written first → no commit until tag 0 is written; then tags 0 and 1 commit on consecutive cycles.
- Allocate 16 entries → full=1; a 17th alloc_valid is ignored (tail stays 0). Commit one → full=0. Tail and head wrap 15→0 correctly.
- JALR pred_pc=32'h100, RS topc=32'h200 value=32'h84 → commit_we with 32'h84, then clear=1 with clear_pc=32'h200; a younger pending entry is discarded and count=0.
- BRANCH pred_taken=0, value bit0=1, target=32'h40 → clear=1, clear_pc=32'h40. With pred_taken=1 and value bit0=1 → no clear.
- Query q_tag_j=3 after tag 3 is written with 32'h55 → q_ready_j=1, q_value_j=32'h55. Assert rst mid-sequence → all outputs 0 and full=0 immediately.
